can_bit_stuffer: RTL
====================

// Module: can_bit_stuffer
// PURPOSE
//  Tx-side bit stuffer, upstream of the bus and mirror of the Rx destuffer. Accepts unstuffed
//  frame bits from the frame serializer via valid/ready, one bit per CLKS_PER_BIT clocks.
//  Drives o_Tx_Serial, inserting a complement bit after 5 equal consecutive bits while
//  stuffing is enabled (SOF..CRC end).
// PARAMETERS
//  CLKS_PER_BIT  10  clocks per nominal bit time (>=2)
// PORTS
//  i_Clock        in   1   system clock; all logic on rising edge
//  i_Rst_n        in   1   synchronous reset, active low
//  i_Bit          in   1   unstuffed data bit (0=dominant)
//  i_Bit_Valid    in   1   i_Bit valid
//  o_Bit_Ready    out  1   stuffer accepts i_Bit this cycle
//  i_Frame_Start  in   1   qualifies accepted bit as SOF; clears run counter (and CRC)
//  i_Stuff_En     in   1   stuffing active; sampled with each accepted bit
//  o_Tx_Serial    out  1   bus bit, 1=recessive
//  o_Stuff_Bit    out  1   high while a stuff bit is on o_Tx_Serial
//  o_Busy         out  1   high in DATA/STUFF
//  o_Underrun     out  1   1-clk pulse: bit period ended, no next bit, mid-frame
//  o_Crc          out  15  CRC-15 over accepted data bits (see CONFIGURATION)
// BEHAVIOUR
//  Reset (i_Rst_n=0 at edge): state IDLE, o_Tx_Serial=1, o_Bit_Ready=1, o_Stuff_Bit=0,
//   o_Busy=0, o_Underrun=0, run count=0, last bit=1, bit timer=0, o_Crc=0. Reset mid-bit
//   aborts the bit immediately; no stuff bit is emitted after release.
//  Accept = i_Bit_Valid & o_Bit_Ready. The accepted bit appears on o_Tx_Serial the next
//   clock and is held exactly CLKS_PER_BIT clocks.
//  Bit timer 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); "last" = timer==CLKS_PER_BIT-1.
//  FSM:
//   IDLE : o_Tx_Serial=1, ready=1. Accept -> DATA.
//   DATA : drive data bit. On last: stuff_due -> STUFF (ready=0); else ready=1;
//          accept -> DATA (back-to-back, no gap); no accept -> IDLE.
//   STUFF: drive ~last bit, o_Stuff_Bit=1. On last: ready=1; accept -> DATA; else IDLE.
//  Run counter (3 bit): on accept with i_Frame_Start: run=1, last=i_Bit. Otherwise,
//   bit==last: run+1; else run=1, last=bit. A stuff bit sets run=1, last=stuff value.
//  stuff_due = (run==5) & stuff_en latched at acceptance of that 5th bit.
//   Stuffing disabled (i_Stuff_En=0): run counted, never inserts; run saturates at 5.
//  Stuff bit of 5 dominants = 1, of 5 recessives = 0; stuff bit may start a new run.
//  Underrun: DATA/STUFF last cycle, no accept, latched stuff_en=1 -> pulse o_Underrun,
//   run cleared. Gap with stuff_en=0 (EOF/IFS) is silent.
//  Simultaneous i_Frame_Start with pending stuff: stuff bit emitted first (ready=0 blocks).
//  Inputs other than during accept are ignored.
// CONFIGURATION
//  CAN_STUFF_CRC_EN defined: o_Crc = CAN CRC-15 (poly 15'h4599, init 0) shifted with each
//   accepted data bit when i_Stuff_En=1; stuff bits excluded; cleared on Frame_Start
//   accept (then SOF bit shifted in). Undefined: o_Crc tied 15'h0, no CRC logic.
// STRUCTURE
//  can_pkg: CAN_STUFF_LIMIT=5, CAN_CRC15_POLY=15'h4599, state encodings IDLE/DATA/STUFF.
//  Sub-module can_crc15 (i_Clock,i_Rst_n,i_Clear,i_Shift,i_Bit,o_Crc), instantiated only
//   under CAN_STUFF_CRC_EN; reusable by the Rx path.
// TESTING
//  Reset mid-bit at timer=4 -> next clk o_Tx_Serial=1, ready=1, no stuff bit after release.
//  SOF + bits 0,0,0,0 (5 dominants), Stuff_En=1 -> wire 000001 then next bit; o_Stuff_Bit
//   high for 10 clks on 6th bit; ready low throughout STUFF.
//  Bits 11111 0, Stuff_En=1 -> wire 11111 0 0 (stuff=0 then data 0); run=2 after.
//  Stuff-bit chain: 00000 1111 -> wire 00000 1 1111 then stuff 0 (stuff starts run).
//  Same 5 dominants with Stuff_En=0 -> no insertion; gap after -> IDLE, no o_Underrun.
//  Valid dropped after 3rd bit, Stuff_En=1 -> o_Underrun 1 clk, line recessive.
//  CAN_STUFF_CRC_EN: frame bits 0 (SOF), ID 11'h123, RTR0, IDE0, r0, DLC 0 -> o_Crc equals
//   bench reference CRC-15; undefined build -> o_Crc==0.
//  Back-to-back 20 bits: each held exactly 10 clks, no gap cycle between.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN definitions: stuffing limit, CRC-15 polynomial, Tx stuffer states and a CRC step helper.
// Used by the Tx stuffer and reusable by the Rx destuffer path.
package can_pkg;

  localparam int          CAN_STUFF_LIMIT = 5;
  localparam logic [14:0] CAN_CRC15_POLY  = 15'h4599;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STUFF = 2'd2
  } stuff_state_e;

  // One serial CRC-15 step: feedback is the incoming bit XOR the register MSB.
  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[14];
    return {crc[13:0], 1'b0} ^ (fb ? CAN_CRC15_POLY : 15'h0);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 accumulator (poly 15'h4599, init 0); i_Clear together with i_Shift
// restarts the CRC from zero and shifts the bit in the same clock.
module can_crc15
  import can_pkg::*;
(
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_Clear,
  input  logic        i_Shift,
  input  logic        i_Bit,
  output logic [14:0] o_Crc
);

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      o_Crc <= '0;
    end else if (i_Shift) begin
      o_Crc <= crc15_step(i_Clear ? 15'h0 : o_Crc, i_Bit);
    end else if (i_Clear) begin
      o_Crc <= '0;
    end
  end

endmodule

// File: rtl/can_bit_stuffer.sv
// CAN Tx bit stuffer: holds each accepted bit CLKS_PER_BIT clocks and inserts a complement
// bit after 5 equal bits while stuffing is enabled. Optional CRC-15: define CAN_STUFF_CRC_EN.
module can_bit_stuffer
  import can_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_Bit,
  input  logic        i_Bit_Valid,
  output logic        o_Bit_Ready,
  input  logic        i_Frame_Start,
  input  logic        i_Stuff_En,
  output logic        o_Tx_Serial,
  output logic        o_Stuff_Bit,
  output logic        o_Busy,
  output logic        o_Underrun,
  output logic [14:0] o_Crc
);

  localparam int          TW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_PRE  = TW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]  RUN_MAX = 3'(CAN_STUFF_LIMIT);

  stuff_state_e  state;
  logic [TW-1:0] timer;
  logic [2:0]    run;
  logic          last_bit;
  logic          stuff_en_q;

  logic          accept;
  logic          timer_last;
  logic          stuff_due;
  logic [2:0]    run_acc;

  assign accept     = i_Bit_Valid & o_Bit_Ready;
  assign timer_last = (timer == T_LAST);
  // stuff_en_q is the enable captured with the bit that completed the run.
  assign stuff_due  = (run == RUN_MAX) & stuff_en_q;

  // Run length after accepting i_Bit; saturates so a disabled stretch never wraps.
  always_comb begin
    // NOTE: default assigned first so every path drives run_acc and no latch is inferred.
    run_acc = 3'd1;
    if (!i_Frame_Start && (i_Bit == last_bit)) begin
      run_acc = (run == RUN_MAX) ? run : run + 3'd1;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      // NOTE: reset is synchronous; a reset mid-bit drops the bit and any pending stuff.
      state       <= IDLE;
      timer       <= '0;
      run         <= 3'd0;
      last_bit    <= 1'b1;
      stuff_en_q  <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Bit_Ready <= 1'b1;
      o_Stuff_Bit <= 1'b0;
      o_Busy      <= 1'b0;
      o_Underrun  <= 1'b0;
    end else begin
      o_Underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= DATA;
            timer       <= '0;
            run         <= run_acc;
            last_bit    <= i_Bit;
            stuff_en_q  <= i_Stuff_En;
            o_Tx_Serial <= i_Bit;
            o_Stuff_Bit <= 1'b0;
            o_Busy      <= 1'b1;
            o_Bit_Ready <= 1'b0;
          end
        end

        DATA, STUFF: begin
          if (!timer_last) begin
            timer       <= timer + 1'b1;
            // Ready opens for the final clock of the bit unless a stuff bit must follow.
            o_Bit_Ready <= (timer == T_PRE) && !((state == DATA) && stuff_due);
          end else if ((state == DATA) && stuff_due) begin
            state       <= STUFF;
            timer       <= '0;
            run         <= 3'd1;
            last_bit    <= ~last_bit;
            o_Tx_Serial <= ~last_bit;
            o_Stuff_Bit <= 1'b1;
            o_Bit_Ready <= 1'b0;
          end else if (accept) begin
            state       <= DATA;
            timer       <= '0;
            run         <= run_acc;
            last_bit    <= i_Bit;
            stuff_en_q  <= i_Stuff_En;
            o_Tx_Serial <= i_Bit;
            o_Stuff_Bit <= 1'b0;
            o_Bit_Ready <= 1'b0;
          end else begin
            state       <= IDLE;
            timer       <= '0;
            o_Tx_Serial <= 1'b1;
            o_Stuff_Bit <= 1'b0;
            o_Busy      <= 1'b0;
            o_Bit_Ready <= 1'b1;
            // A gap inside the stuffed region is an underrun; EOF/IFS gaps are silent.
            if (stuff_en_q) begin
              o_Underrun <= 1'b1;
              run        <= 3'd0;
            end
          end
        end

        default: begin
          state       <= IDLE;
          timer       <= '0;
          o_Tx_Serial <= 1'b1;
          o_Stuff_Bit <= 1'b0;
          o_Busy      <= 1'b0;
          o_Bit_Ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef CAN_STUFF_CRC_EN
  can_crc15 u_crc15 (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .i_Clear (accept & i_Frame_Start),
    .i_Shift (accept & i_Stuff_En),
    .i_Bit   (i_Bit),
    .o_Crc   (o_Crc)
  );
`else
  assign o_Crc = 15'h0;
`endif

endmodule
